cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter.sv | 163 ++++++++++++++++
 tb/tb_cdb_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
//   Arbitrates ALU and LSU results onto a single registered common data bus.
//   Each producer port owns a one-entry holding buffer; arbitration looks only
//   at buffered entries, so an accepted result reaches the CDB two cycles
//   after its transfer when uncontended, and the bus sustains one broadcast
//   per cycle.
//
//   Ties are resolved round-robin by default (ALU wins the first tie after
//   reset). Defining CDB_ARB_FIXED_PRIO_EN makes every tie go to the ALU.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   flush                       squash all buffered and in-flight results
//   alu_valid/tag/data, ready   ALU result handshake
//   lsu_valid/tag/data, ready   LSU result handshake
//   cdb_valid/tag/data          registered broadcast, one cycle per result
//   conflict_cnt                saturating count of cycles with both pending
// ---------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int TAG_W  = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              alu_valid,
    input  logic [TAG_W-1:0]  alu_tag,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              lsu_valid,
    input  logic [TAG_W-1:0]  lsu_tag,
    input  logic [DATA_W-1:0] lsu_data,
    output logic              lsu_ready,
    output logic              cdb_valid,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data,
    output logic [15:0]       conflict_cnt
);

    logic              pend_v_alu;
    logic [TAG_W-1:0]  pend_tag_alu;
    logic [DATA_W-1:0] pend_data_alu;
    logic              pend_v_lsu;
    logic [TAG_W-1:0]  pend_tag_lsu;
    logic [DATA_W-1:0] pend_data_lsu;

    logic grant_alu;
    logic grant_lsu;
    logic alu_fire;
    logic lsu_fire;

`ifndef CDB_ARB_FIXED_PRIO_EN
    typedef enum logic {
        PORT_ALU = 1'b0,
        PORT_LSU = 1'b1
    } port_e;

    port_e last_grant;
`endif

    // Grant decision: only buffered entries compete; flush suppresses all.
    always_comb begin
        grant_alu = 1'b0;
        grant_lsu = 1'b0;
        if (!flush) begin
            if (pend_v_alu && pend_v_lsu) begin
`ifdef CDB_ARB_FIXED_PRIO_EN
                grant_alu = 1'b1;
`else
                if (last_grant == PORT_LSU) begin
                    grant_alu = 1'b1;
                end else begin
                    grant_lsu = 1'b1;
                end
`endif
            end else begin
                grant_alu = pend_v_alu;
                grant_lsu = pend_v_lsu;
            end
        end
    end

    // A granted buffer drains this edge, so it can take a new result in the
    // same cycle; that keeps one broadcast per cycle per port.
    assign alu_ready = ~flush & (~pend_v_alu | grant_alu);
    assign lsu_ready = ~flush & (~pend_v_lsu | grant_lsu);
    assign alu_fire  = alu_valid & alu_ready;
    assign lsu_fire  = lsu_valid & lsu_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_v_alu    <= 1'b0;
            pend_tag_alu  <= '0;
            pend_data_alu <= '0;
        end else if (flush) begin
            pend_v_alu <= 1'b0;
        end else if (alu_fire) begin
            pend_v_alu    <= 1'b1;
            pend_tag_alu  <= alu_tag;
            pend_data_alu <= alu_data;
        end else if (grant_alu) begin
            pend_v_alu <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_v_lsu    <= 1'b0;
            pend_tag_lsu  <= '0;
            pend_data_lsu <= '0;
        end else if (flush) begin
            pend_v_lsu <= 1'b0;
        end else if (lsu_fire) begin
            pend_v_lsu    <= 1'b1;
            pend_tag_lsu  <= lsu_tag;
            pend_data_lsu <= lsu_data;
        end else if (grant_lsu) begin
            pend_v_lsu <= 1'b0;
        end
    end

    // Broadcast register: tag/data hold when nothing is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
        end else if (grant_alu) begin
            cdb_valid <= 1'b1;
            cdb_tag   <= pend_tag_alu;
            cdb_data  <= pend_data_alu;
        end else if (grant_lsu) begin
            cdb_valid <= 1'b1;
            cdb_tag   <= pend_tag_lsu;
            cdb_data  <= pend_data_lsu;
        end else begin
            cdb_valid <= 1'b0;
        end
    end

`ifndef CDB_ARB_FIXED_PRIO_EN
    // Reset to LSU so the ALU takes the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= PORT_LSU;
        end else if (grant_alu) begin
            last_grant <= PORT_ALU;
        end else if (grant_lsu) begin
            last_grant <= PORT_LSU;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
        end else if (pend_v_alu && pend_v_lsu && !flush && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_arbiter
//   Directed, table-driven bench for cdb_arbiter (default round-robin build).
//   Each table row is one clock cycle: inputs driven at the falling edge and
//   the expected ready / CDB / conflict_cnt values checked 1 ns later.
//   Hand-written sequences cover asynchronous reset mid-stream and
//   conflict_cnt saturation.
// ---------------------------------------------------------------------------
module tb_cdb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        alu_valid;
    logic [4:0]  alu_tag;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        lsu_valid;
    logic [4:0]  lsu_tag;
    logic [31:0] lsu_data;
    logic        lsu_ready;
    logic        cdb_valid;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic [15:0] conflict_cnt;

    int tests;
    int fails;

    cdb_arbiter #(
        .TAG_W (5),
        .DATA_W(32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .alu_valid   (alu_valid),
        .alu_tag     (alu_tag),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .lsu_valid   (lsu_valid),
        .lsu_tag     (lsu_tag),
        .lsu_data    (lsu_data),
        .lsu_ready   (lsu_ready),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_data    (cdb_data),
        .conflict_cnt(conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic        av;
        logic [4:0]  at;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  lt;
        logic [31:0] ld;
        logic        ear;
        logic        elr;
        logic        ecv;
        logic [4:0]  ect;
        logic [31:0] ecd;
        logic [15:0] ecnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic fl,
                                input logic av, input int at, input int ad,
                                input logic lv, input int lt, input int ld,
                                input logic ear, input logic elr,
                                input logic ecv, input int ect, input int ecd,
                                input int ecnt);
        vec_t v;
        v.fl   = fl;
        v.av   = av;
        v.at   = at[4:0];
        v.ad   = ad;
        v.lv   = lv;
        v.lt   = lt[4:0];
        v.ld   = ld;
        v.ear  = ear;
        v.elr  = elr;
        v.ecv  = ecv;
        v.ect  = ect[4:0];
        v.ecd  = ecd;
        v.ecnt = ecnt[15:0];
        return v;
    endfunction

    function automatic vec_t idle(input logic ear, input logic elr,
                                  input logic ecv, input int ect, input int ecd,
                                  input int ecnt);
        return mk(1'b0, 1'b0, 0, 0, 1'b0, 0, 0, ear, elr, ecv, ect, ecd, ecnt);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        flush     = 1'b0;
        alu_valid = 1'b0;
        alu_tag   = '0;
        alu_data  = '0;
        lsu_valid = 1'b0;
        lsu_tag   = '0;
        lsu_data  = '0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        drive_idle();

        // Two ports accepted together after reset: ALU first, then LSU.
        vecs.push_back(mk(0, 1, 1, 'hA1, 1, 2, 'hB2, 1, 1, 0, 0, 0, 0));
        vecs.push_back(idle(1, 0, 0, 0, 0, 0));
        vecs.push_back(idle(1, 1, 1, 1, 'hA1, 1));
        vecs.push_back(idle(1, 1, 1, 2, 'hB2, 1));
        vecs.push_back(idle(1, 1, 0, 2, 'hB2, 1));
        // Six cycles of continuous traffic on both ports; next tag offered
        // only after the previous one was accepted.
        vecs.push_back(mk(0, 1, 4, 'hA04, 1, 20, 'hB14, 1, 1, 0, 2, 'hB2, 1));
        vecs.push_back(mk(0, 1, 5, 'hA05, 1, 21, 'hB15, 1, 0, 0, 2, 'hB2, 1));
        vecs.push_back(mk(0, 1, 6, 'hA06, 1, 21, 'hB15, 0, 1, 1, 4, 'hA04, 2));
        vecs.push_back(mk(0, 1, 6, 'hA06, 1, 22, 'hB16, 1, 0, 1, 20, 'hB14, 3));
        vecs.push_back(mk(0, 1, 7, 'hA07, 1, 22, 'hB16, 0, 1, 1, 5, 'hA05, 4));
        vecs.push_back(mk(0, 1, 7, 'hA07, 1, 23, 'hB17, 1, 0, 1, 21, 'hB15, 5));
        vecs.push_back(idle(0, 1, 1, 6, 'hA06, 6));
        vecs.push_back(idle(1, 1, 1, 22, 'hB16, 7));
        vecs.push_back(idle(1, 1, 1, 7, 'hA07, 7));
        vecs.push_back(idle(1, 1, 0, 7, 'hA07, 7));
        // Single uncontended ALU result: two-cycle latency, one-cycle pulse.
        vecs.push_back(mk(0, 1, 3, 'h11, 0, 0, 0, 1, 1, 0, 7, 'hA07, 7));
        vecs.push_back(idle(1, 1, 0, 7, 'hA07, 7));
        vecs.push_back(idle(1, 1, 1, 3, 'h11, 7));
        vecs.push_back(idle(1, 1, 0, 3, 'h11, 7));
        // Flush with both buffers full; an ALU offer during flush is refused.
        vecs.push_back(mk(0, 1, 8, 'hA08, 1, 24, 'hB18, 1, 1, 0, 3, 'h11, 7));
        vecs.push_back(mk(1, 1, 9, 'hA09, 0, 0, 0, 0, 0, 0, 3, 'h11, 7));
        vecs.push_back(idle(1, 1, 0, 3, 'h11, 7));
        vecs.push_back(idle(1, 1, 0, 3, 'h11, 7));
        // last_grant survived the flush (ALU), so this tie goes to LSU.
        vecs.push_back(mk(0, 1, 10, 'hA0A, 1, 25, 'hB19, 1, 1, 0, 3, 'h11, 7));
        vecs.push_back(idle(0, 1, 0, 3, 'h11, 7));
        vecs.push_back(idle(1, 1, 1, 25, 'hB19, 8));
        vecs.push_back(idle(1, 1, 1, 10, 'hA0A, 8));
        vecs.push_back(idle(1, 1, 0, 10, 'hA0A, 8));

        repeat (2) @(posedge clk);
        #1;
        check("reset_cdb_valid", {31'd0, cdb_valid}, 32'd0);
        check("reset_cnt", {16'd0, conflict_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            flush     = vecs[i].fl;
            alu_valid = vecs[i].av;
            alu_tag   = vecs[i].at;
            alu_data  = vecs[i].ad;
            lsu_valid = vecs[i].lv;
            lsu_tag   = vecs[i].lt;
            lsu_data  = vecs[i].ld;
            #1;
            check($sformatf("row%0d_alu_ready", i), {31'd0, alu_ready}, {31'd0, vecs[i].ear});
            check($sformatf("row%0d_lsu_ready", i), {31'd0, lsu_ready}, {31'd0, vecs[i].elr});
            check($sformatf("row%0d_cdb_valid", i), {31'd0, cdb_valid}, {31'd0, vecs[i].ecv});
            check($sformatf("row%0d_cdb_tag", i), {27'd0, cdb_tag}, {27'd0, vecs[i].ect});
            check($sformatf("row%0d_cdb_data", i), cdb_data, vecs[i].ecd);
            check($sformatf("row%0d_conflict_cnt", i), {16'd0, conflict_cnt}, {16'd0, vecs[i].ecnt});
        end

        // Reset asserted while ALU tag 13 sits in its buffer.
        @(negedge clk);
        drive_idle();
        alu_valid = 1'b1;
        alu_tag   = 5'd13;
        alu_data  = 32'hDEAD;
        #1;
        check("rst_seq_accept", {31'd0, alu_ready}, 32'd1);
        @(negedge clk);
        alu_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_cdb_valid", {31'd0, cdb_valid}, 32'd0);
        check("rst_cdb_tag", {27'd0, cdb_tag}, 32'd0);
        check("rst_cdb_data", cdb_data, 32'd0);
        check("rst_conflict_cnt", {16'd0, conflict_cnt}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_alu_ready", {31'd0, alu_ready}, 32'd1);
        check("post_rst_lsu_ready", {31'd0, lsu_ready}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("post_rst_cdb_valid_%0d", k), {31'd0, cdb_valid}, 32'd0);
            check($sformatf("post_rst_cdb_tag_%0d", k), {27'd0, cdb_tag}, 32'd0);
        end

        // Saturation: both ports valid continuously keeps both buffers full,
        // so every edge after the first accept is a contention cycle.
        @(negedge clk);
        alu_valid = 1'b1;
        alu_tag   = 5'd1;
        alu_data  = 32'h1;
        lsu_valid = 1'b1;
        lsu_tag   = 5'd2;
        lsu_data  = 32'h2;
        repeat (65535) @(posedge clk);
        @(negedge clk);
        #1;
        check("sat_preload", {16'd0, conflict_cnt}, 32'hFFFE);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("sat_reach", {16'd0, conflict_cnt}, 32'hFFFF);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("sat_hold", {16'd0, conflict_cnt}, 32'hFFFF);
        check("sat_cdb_valid", {31'd0, cdb_valid}, 32'd1);
        drive_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
